seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver_if.sv | 25 ++
 rtl/seg_scan_driver.sv | 109 ++++++++++
 2 files changed

// File: rtl/seg_scan_driver_if.sv
// Bundle for the segment scan driver: display value and decimal-point mask in,
// registered segment/digit drive and frame-capture pulse out.
interface seg_scan_driver_if;
  logic [31:0] SegData;
  logic [7:0]  DpMask;
  logic [7:0]  SegOut;
  logic [7:0]  DigitSel;
  logic        FrameDone;

  modport master (
    output SegData,
    output DpMask,
    input  SegOut,
    input  DigitSel,
    input  FrameDone
  );

  modport slave (
    input  SegData,
    input  DpMask,
    output SegOut,
    output DigitSel,
    output FrameDone
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 8-digit 7-segment scan driver with tear-free frame capture.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading-zero digits (digit 0 never blanked).
module seg_scan_driver #(
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  seg_scan_driver_if.slave  bus
);

  localparam int            PW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] DIV_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_r;
  logic [2:0]    idx_r;
  logic [31:0]   shadow_data_r;
  logic [7:0]    shadow_dp_r;
  logic [7:0]    seg_out_r;
  logic [7:0]    digit_sel_r;
  logic          frame_done_r;

  logic          tick_s;
  logic          load_s;
  logic [2:0]    next_idx_s;
  logic [31:0]   src_data_s;
  logic [7:0]    src_dp_s;
  logic [3:0]    nibble_s;
  logic          blank_s;
  logic [7:0]    seg_next_s;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      4'hF:    pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  // Next-digit selection; on the load edge decode straight from the incoming value.
  always_comb begin
    tick_s     = (presc_r == DIV_MAX);
    next_idx_s = idx_r + 3'd1;
    load_s     = tick_s && (idx_r == 3'd7);
    src_data_s = load_s ? bus.SegData : shadow_data_r;
    src_dp_s   = load_s ? bus.DpMask  : shadow_dp_r;
    nibble_s   = src_data_s[{next_idx_s, 2'b00} +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    blank_s    = (next_idx_s != 3'd0) && ((src_data_s >> {next_idx_s, 2'b00}) == 32'd0);
`else
    blank_s    = 1'b0;
`endif
    seg_next_s = {src_dp_s[next_idx_s], (blank_s ? 7'h00 : hex_decode(nibble_s))};
  end

  // Digit-slot prescaler.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Index starts at 7 so the first tick after reset is also a frame capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r         <= 3'd7;
      shadow_data_r <= 32'h0000_0000;
      shadow_dp_r   <= 8'h00;
      seg_out_r     <= 8'h00;
      digit_sel_r   <= 8'h00;
      frame_done_r  <= 1'b0;
    end else begin
      frame_done_r <= load_s;
      if (tick_s) begin
        idx_r       <= next_idx_s;
        digit_sel_r <= 8'd1 << next_idx_s;
        seg_out_r   <= seg_next_s;
        if (load_s) begin
          shadow_data_r <= bus.SegData;
          shadow_dp_r   <= bus.DpMask;
        end
      end
    end
  end

  assign bus.SegOut    = seg_out_r;
  assign bus.DigitSel  = digit_sel_r;
  assign bus.FrameDone = frame_done_r;

endmodule
